// File: rtl/solo_squash_input_conditioner.sv
// Input conditioner for solo_squash: synchronises and debounces the active-low
// buttons and external reset, and holds the game in reset through a power-up hold-off.
module solo_squash_input_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 262144,
    parameter int HOLDOFF_CYCLES  = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_reset_n_in,
    input  logic [NUM_BUTTONS-1:0] btn_n_in,
    output logic                   game_reset,
    output logic [NUM_BUTTONS-1:0] btn_n_out,
    output logic [NUM_BUTTONS-1:0] btn_press
);

    localparam int MAX_COUNT = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_HOLDOFF   = 2'd0;
    localparam logic [1:0] ST_EXT_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic [NUM_BUTTONS-1:0] btn_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ext_sync;
    logic [NUM_BUTTONS-1:0] btn_y;
    logic                   ext_y;

    logic [CNT_W-1:0]       db_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] accept;
    logic [NUM_BUTTONS-1:0] fall;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       ctrl_cnt;
    logic [CNT_W-1:0]       ctrl_cnt_next;

    // ext_reset synchroniser resets to 0 so the game reset starts asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                btn_sync[s] <= '1;
            end
            ext_sync <= '0;
        end else begin
            btn_sync[0] <= btn_n_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                btn_sync[s] <= btn_sync[s-1];
            end
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_reset_n_in};
        end
    end

    assign btn_y = btn_sync[SYNC_STAGES-1];
    assign ext_y = ext_sync[SYNC_STAGES-1];

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            accept[i] = (btn_y[i] != stable[i]) && (db_cnt[i] == DEB_LAST);
        end
        fall = accept & stable;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (btn_y[i] == stable[i] || accept[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // One counter serves both the hold-off timer and the ext_reset release debounce
    always_comb begin
        state_next    = state;
        ctrl_cnt_next = ctrl_cnt;
        case (state)
            ST_HOLDOFF: begin
                if (ctrl_cnt == HOLD_LAST) begin
                    state_next    = ST_EXT_CHECK;
                    ctrl_cnt_next = '0;
                end else begin
                    ctrl_cnt_next = ctrl_cnt + CNT_ONE;
                end
            end
            ST_EXT_CHECK: begin
                if (!ext_y) begin
                    ctrl_cnt_next = '0;
                end else if (ctrl_cnt == DEB_LAST) begin
                    state_next    = ST_RUN;
                    ctrl_cnt_next = '0;
                end else begin
                    ctrl_cnt_next = ctrl_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!ext_y) begin
                    state_next    = ST_EXT_CHECK;
                    ctrl_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_HOLDOFF;
                ctrl_cnt_next = '0;
            end
        endcase
    end

    // Press pulses are gated by the next game_reset so they never overlap an asserted reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HOLDOFF;
            ctrl_cnt   <= '0;
            game_reset <= 1'b1;
            btn_press  <= '0;
        end else begin
            state      <= state_next;
            ctrl_cnt   <= ctrl_cnt_next;
            game_reset <= (state_next != ST_RUN);
            btn_press  <= fall & {NUM_BUTTONS{state_next == ST_RUN}};
        end
    end

    assign btn_n_out = stable;

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
// Bench for solo_squash_input_conditioner: hand-derived vector table, corner-case
// sequences, then randomised stimulus against a window-based reference model.
module tb_solo_squash_input_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_reset_n_in;
    logic [3:0] btn_n_in;
    logic       game_reset;
    logic [3:0] btn_n_out;
    logic [3:0] btn_press;

    int checks   = 0;
    int failures = 0;

    solo_squash_input_conditioner #(
        .NUM_BUTTONS    (4),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_reset_n_in(ext_reset_n_in),
        .btn_n_in      (btn_n_in),
        .game_reset    (game_reset),
        .btn_n_out     (btn_n_out),
        .btn_press     (btn_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       ext;
        logic       exp_gr;
        logic [3:0] exp_out;
        logic [3:0] exp_press;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a level is accepted once the last DB synchronised samples all
    // disagree with it; release of ext_reset needs DB consecutive highs after hold-off.
    logic [3:0] sync_q[$];
    logic       ext_q[$];
    logic [3:0] y_hist[$];
    int         edge_n;
    int         ones;
    bit         run;
    logic       m_gr;
    logic [3:0] m_s;
    logic [3:0] m_press;

    task automatic model_reset();
        sync_q = {};
        ext_q  = {};
        y_hist = {};
        for (int i = 0; i < SYNC; i++) begin
            sync_q.push_back(4'hF);
            ext_q.push_back(1'b0);
        end
        edge_n  = 0;
        ones    = 0;
        run     = 0;
        m_gr    = 1'b1;
        m_s     = 4'hF;
        m_press = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] y;
        logic [3:0] new_s;
        logic       ye;
        bit         all_diff;
        y  = sync_q.pop_front();
        sync_q.push_back(btn_n_in);
        ye = ext_q.pop_front();
        ext_q.push_back(ext_reset_n_in);
        y_hist.push_back(y);
        if (y_hist.size() > DB) void'(y_hist.pop_front());
        new_s = m_s;
        if (y_hist.size() == DB) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1;
                for (int k = 0; k < DB; k++) begin
                    if (y_hist[k][b] == m_s[b]) all_diff = 0;
                end
                if (all_diff) new_s[b] = ~m_s[b];
            end
        end
        if (edge_n < HOLD) begin
            edge_n++;
        end else if (run) begin
            if (!ye) begin
                run  = 0;
                ones = 0;
            end
        end else begin
            ones = ye ? ones + 1 : 0;
            if (ones >= DB) run = 1;
        end
        m_gr    = !run;
        m_press = m_s & ~new_s & {4{~m_gr}};
        m_s     = new_s;
    endtask

    initial model_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic gr, input logic [3:0] out, input logic [3:0] press);
        check_output({tag, " game_reset"}, {3'b0, game_reset}, {3'b0, gr});
        check_output({tag, " btn_n_out"}, btn_n_out, out);
        check_output({tag, " btn_press"}, btn_press, press);
    endtask

    task automatic apply_stimulus(input logic [3:0] btn, input logic ext);
        btn_n_in       = btn;
        ext_reset_n_in = ext;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [3:0] btn, input logic ext, input logic gr,
                           input logic [3:0] out, input logic [3:0] press);
        vec_t v;
        v.btn = btn; v.ext = ext; v.exp_gr = gr; v.exp_out = out; v.exp_press = press;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        ext_reset_n_in = 1'b1;
        btn_n_in       = 4'hF;

        // Power-up hold-off plus release debounce, then a clean press/release on bit 2
        for (int i = 0; i < 14; i++) add_vec(4'hF, 1'b1, (i < 11), 4'hF, 4'h0);
        for (int k = 0; k < 8; k++) add_vec(4'b1011, 1'b1, 1'b0, (k >= 5) ? 4'b1011 : 4'hF, (k == 5) ? 4'b0100 : 4'h0);
        for (int k = 0; k < 7; k++) add_vec(4'hF, 1'b1, 1'b0, (k >= 5) ? 4'hF : 4'b1011, 4'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b1, 4'hF, 4'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].btn, vecs[i].ext);
            check_all($sformatf("vec%0d", i), vecs[i].exp_gr, vecs[i].exp_out, vecs[i].exp_press);
        end

        // Bounce: 3-cycle lows never reach the 4-sample threshold
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                apply_stimulus((k < 3) ? 4'b1110 : 4'hF, 1'b1);
                check_all($sformatf("bounce%0d_%0d", r, k), 1'b0, 4'hF, 4'h0);
            end
        end
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(4'b1110, 1'b1);
            check_all($sformatf("final_low%0d", k), 1'b0, (k >= 5) ? 4'b1110 : 4'hF, (k == 5) ? 4'b0001 : 4'h0);
        end
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(4'hF, 1'b1);
            check_all($sformatf("release0_%0d", k), 1'b0, (k >= 5) ? 4'hF : 4'b1110, 4'h0);
        end

        // External reset: single-cycle low, then a release that bounces at count 2
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(4'hF, (k == 0) ? 1'b0 : 1'b1);
            check_output($sformatf("ext_pulse%0d", k), {3'b0, game_reset}, {3'b0, (k >= 2 && k <= 5)});
        end
        for (int k = 0; k < 11; k++) begin
            apply_stimulus(4'hF, (k == 0 || k == 3) ? 1'b0 : 1'b1);
            check_output($sformatf("ext_bounce%0d", k), {3'b0, game_reset}, {3'b0, (k >= 2 && k <= 8)});
        end

        // Press during hold-off is debounced but never pulses
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(4'b1101, 1'b1);
            check_all($sformatf("holdoff_press%0d", k), 1'b1, (k >= 5) ? 4'b1101 : 4'hF, 4'h0);
        end
        for (int k = 0; k < 20; k++) apply_stimulus(4'hF, 1'b1);
        check_all("after_holdoff", 1'b0, 4'hF, 4'h0);

        // Async reset mid-debounce must act without a clock edge
        for (int k = 0; k < 8; k++) apply_stimulus(4'b1011, 1'b1);
        check_output("held_btn2", btn_n_out, 4'b1011);
        for (int k = 0; k < 4; k++) apply_stimulus(4'b0011, 1'b1);
        check_all("pre_async", 1'b0, 4'b1011, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 1'b1, 4'hF, 4'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Randomised run against the reference model, with occasional async resets
        begin
            logic [3:0] drive;
            drive = 4'hF;
            for (int c = 0; c < 3000; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 7) == 0) drive[b] = ~drive[b];
                end
                reset = ($urandom_range(0, 599) == 0);
                apply_stimulus(drive, ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1);
                check_all($sformatf("rand%0d", c), m_gr, m_s, m_press);
            end
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/solo_squash_input_conditioner.md
Name: solo_squash_input_conditioner

Overview:
Upstream stage between the Caravel GPIO inputs and the solo_squash game core. It synchronises and debounces the four active-low pushbuttons and the active-low external reset, and holds the game in reset during a power-up hold-off while the GPIOs are still unconfigured. Its outputs drive the game's reset and button inputs directly. game_reset also drives the io_oeb hi-Z control.

Parameters:
NUM_BUTTONS, 4, number of active-low button inputs (pause, new_game, down, up in bits 0..3).
SYNC_STAGES, 2, flip-flop depth of every input synchroniser; minimum 2.
DEBOUNCE_CYCLES, 262144, consecutive stable synchronised samples needed to accept a level change; minimum 2 (about 10.5 ms at 25 MHz).
HOLDOFF_CYCLES, 1024, cycles game_reset is forced high after reset deassertion; minimum 1.

Ports:
clk  input  1  system clock (wb_clk_i).
reset  input  1  asynchronous, active-high reset (wb_rst_i).
ext_reset_n_in  input  1  raw external reset button (io_in[8]), active-low, asynchronous to clk.
btn_n_in  input  NUM_BUTTONS  raw active-low buttons (io_in[12:9]), asynchronous to clk.
game_reset  output  1  conditioned reset to the game core and io_oeb, active-high.
btn_n_out  output  NUM_BUTTONS  debounced active-low button levels.
btn_press  output  NUM_BUTTONS  one-cycle pulse per accepted press (debounced 1->0).

Behaviour:
- Reset (async, active-high):
  - All button synchroniser flops and stable levels reset to 1.
  - The ext_reset synchroniser resets to 0 (asserted).
  - All counters reset to 0. The hold-off counter is loaded so hold-off is active.
  - Output reset values: game_reset=1, btn_n_out=all 1s, btn_press=0.
- Synchroniser:
  - SYNC_STAGES flops per input, all on clk.
  - No logic between stages.
- Button debounce, per bit, independent of the other bits:
  - Each bit holds a stable level S and a counter C.
  - Each edge, the last synchroniser stage Y is compared with S.
  - If Y==S, C<=0.
  - If Y!=S and C<DEBOUNCE_CYCLES-1, C<=C+1.
  - If Y!=S and C==DEBOUNCE_CYCLES-1, then S<=Y and C<=0.
  - Any single-cycle agreement (glitch) clears C; counting restarts from 0.
  - Latency: a clean pin change appears on btn_n_out exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- btn_press:
  - Registered. It is 1 for exactly the one cycle following the edge where S goes 1->0.
  - It is forced to 0 while game_reset is 1.
  - Releases (0->1) produce no pulse.
  - Simultaneous presses on several bits pulse together.
- Debouncers keep running while game_reset is high; only the async reset clears them.
- game_reset control, three states:
  - HOLDOFF (entered on reset): game_reset=1. The counter counts 0..HOLDOFF_CYCLES-1, then moves to EXT_CHECK.
  - EXT_CHECK: game_reset=1 while the synchronised ext_reset_n is 0. A release counter requires DEBOUNCE_CYCLES consecutive samples of 1; any 0 sample clears it. On reaching DEBOUNCE_CYCLES, move to RUN.
  - RUN: game_reset=0. A single synchronised sample of ext_reset_n=0 returns to EXT_CHECK with game_reset=1 on that same edge. Assertion is not debounced; release is.
- Minimum game_reset width after reset deassertion: HOLDOFF_CYCLES + DEBOUNCE_CYCLES cycles, even with ext_reset_n tied high.
- Counter widths are sized by clog2 of the largest parameter plus 1; counters must never wrap.
- Async reset mid-debounce or mid-holdoff aborts immediately to reset values.

Test Plan:
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
1. Power-up: assert reset 3 cycles, then release with ext_reset_n_in=1 and btn_n_in=4'b1111 -> game_reset stays 1 for exactly 12 cycles (8 hold-off + 4 release debounce), then falls to 0; btn_n_out=4'b1111 throughout; btn_press=0 throughout.
2. Clean press in RUN: drive btn_n_in[2] 1->0 and hold -> btn_n_out[2] falls exactly 6 edges after the first sampling edge; btn_press=4'b0100 for one cycle; a later release gives no pulse.
3. Bounce: toggle btn_n_in[0] with low pulses of 3 cycles separated by 1-cycle highs -> btn_n_out[0] stays 1 and btn_press[0] never pulses; a final 4+ cycle low is accepted.
4. Ext reset in RUN: pulse ext_reset_n_in low for 1 cycle -> game_reset rises 2 edges later; it falls again 4 cycles after the synchronised input returns high. With a bouncing release (low for 1 cycle at count 2), game_reset stays high and the count restarts.
5. Press during game_reset: press btn_n_in[1] for 10 cycles during HOLDOFF -> btn_n_out[1] goes 0; btn_press stays 0.
6. Async reset mid-debounce: press btn_n_in[3], then assert reset at debounce count 2 -> all outputs return to reset values immediately, without waiting for a clk edge.
